// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode 7-segment scan driver for the stopwatch/clock.
// Time fields are snapshotted once per frame so a frame never tears.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_sel,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic          mode_q, mode_d;
  logic [6:0]    msec_q, msec_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [3:0]    comm_q, comm_d;
  logic [7:0]    font_q, font_d;

  logic          wrap;
  logic          frame_end;
  logic [6:0]    lo_v, hi_v, v;
  logic [6:0]    tens, ones;
  logic [3:0]    dig;
  logic          oor;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap        = (scan_cnt_q == LAST);
    frame_end   = wrap && (digit_idx_q == 2'd3);
    scan_cnt_d  = wrap ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = wrap ? digit_idx_q + 2'd1 : digit_idx_q;

    mode_d = frame_end ? mode_sel : mode_q;
    msec_d = frame_end ? msec     : msec_q;
    sec_d  = frame_end ? sec      : sec_q;
    min_d  = frame_end ? min      : min_q;
    hour_d = frame_end ? hour     : hour_q;

    lo_v = mode_q ? {1'b0, min_q}  : msec_q;
    hi_v = mode_q ? {2'b0, hour_q} : {1'b0, sec_q};
    v    = digit_idx_q[1] ? hi_v : lo_v;
    oor  = (v >= 7'd100);
    tens = v / 7'd10;
    ones = v % 7'd10;
    dig  = digit_idx_q[0] ? tens[3:0] : ones[3:0];

    // Out-of-range fields show dashes and never carry the dp
    font_d = oor ? 8'hBF : {1'b1, seg7(dig)};
    if (digit_idx_q == 2'd2 && !oor &&
        (!mode_q || msec_q < 7'd50))
      font_d[7] = 1'b0;
    comm_d = ~(4'b0001 << digit_idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      mode_q      <= 1'b0;
      msec_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      comm_q      <= 4'hF;
      font_q      <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      mode_q      <= mode_d;
      msec_q      <= msec_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      comm_q      <= comm_d;
      font_q      <= font_d;
    end
  end

  assign fnd_comm = comm_q;
  assign fnd_font = font_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with SCAN_DIV=4.
// A frame-level arithmetic model predicts every registered output.
module tb_fnd_scan_controller;

  localparam int D = 4;
  localparam int F = 4 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_sel = 1'b0;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;

  int vecs = 0;
  int errs = 0;

  fnd_scan_controller #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .msec(msec), .sec(sec), .min(min), .hour(hour),
    .fnd_comm(fnd_comm), .fnd_font(fnd_font)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] TAB [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] ref_font(
    input int dg, input bit m, input int ms,
    input int s, input int mi, input int h);
    int lo, hi, v, d;
    logic [7:0] f;
    lo = m ? mi : ms;
    hi = m ? h : s;
    v  = (dg < 2) ? lo : hi;
    if (v >= 100) return 8'hBF;
    d = (dg % 2 == 1) ? v / 10 : v % 10;
    f = TAB[d];
    if (dg == 2 && (!m || ms < 50)) f[7] = 1'b0;
    return f;
  endfunction

  // Model state: cycles since release and the frame's snapshot
  int         t = 0;
  bit         s_mode = 0;
  int         s_ms = 0, s_s = 0, s_mi = 0, s_h = 0;
  logic [3:0] exp_comm = 'x;
  logic [7:0] exp_font = 'x;

  always @(posedge clk) begin
    if (!rst) begin
      t <= 0;
      s_mode <= 0;
      s_ms <= 0; s_s <= 0; s_mi <= 0; s_h <= 0;
      exp_comm <= 4'hF;
      exp_font <= 8'hFF;
    end else begin
      exp_comm <= ~(4'b0001 << ((t / D) % 4));
      exp_font <= ref_font((t / D) % 4, s_mode,
                           s_ms, s_s, s_mi, s_h);
      if (t % F == F - 1) begin
        s_mode <= mode_sel;
        s_ms <= int'(msec); s_s <= int'(sec);
        s_mi <= int'(min);  s_h <= int'(hour);
      end
      t <= t + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== 4'hF || fnd_font !== 8'hFF) begin
        errs++;
        $display("FAIL reset_hold: comm=%b font=%h want 1111/ff",
                 fnd_comm, fnd_font);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (fnd_comm !== 4'b1110 || fnd_font !== 8'hC0) begin
      errs++;
      $display("FAIL reset_release: comm=%b font=%h want 1110/c0",
               fnd_comm, fnd_font);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] ef [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    logic [3:0] ec [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    mode_sel = 0; sec = 12; msec = 34;
    do_reset();
    for (int k = 1; k <= 2 * F; k++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        errs++;
        $display("FAIL mode0_model k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, exp_font);
      end
      if (k > F) begin
        vecs++;
        if (fnd_comm !== ec[(k-F-1)/D] ||
            fnd_font !== ef[(k-F-1)/D]) begin
          errs++;
          $display("FAIL mode0_digit k=%0d: %b/%h want %b/%h",
                   k, fnd_comm, fnd_font,
                   ec[(k-F-1)/D], ef[(k-F-1)/D]);
        end
      end
    end
  endtask

  task automatic test_mode1_blink();
    mode_sel = 1; hour = 5; min = 7; msec = 10;
    do_reset();
    for (int k = 1; k <= 3 * F; k++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        errs++;
        $display("FAIL blink_model k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, exp_font);
      end
      if (k == F + 2*D + 1 || k == F + 3*D + 1 ||
          k == 2*F + 2*D + 1) begin
        logic [7:0] w;
        w = (k == F + 2*D + 1) ? 8'h12 :
            (k == F + 3*D + 1) ? 8'hC0 : 8'h92;
        vecs++;
        if (fnd_font !== w) begin
          errs++;
          $display("FAIL blink_font k=%0d: %h want %h",
                   k, fnd_font, w);
        end
      end
      if (k == F + 4) msec = 60;
    end
  endtask

  task automatic test_range();
    logic [7:0] ef [4] = '{8'hBF, 8'hBF, 8'h10, 8'h92};
    mode_sel = 0; msec = 115; sec = 59;
    do_reset();
    for (int k = 1; k <= 2 * F; k++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        errs++;
        $display("FAIL range_model k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, exp_font);
      end
      if (k > F && fnd_font !== ef[(k-F-1)/D]) begin
        errs++;
        $display("FAIL range_digit k=%0d: %h want %h",
                 k, fnd_font, ef[(k-F-1)/D]);
      end
      if (k > F) vecs++;
    end
  endtask

  task automatic test_frame_boundary();
    mode_sel = 0; sec = 12; msec = 34;
    do_reset();
    for (int k = 1; k <= 3 * F; k++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        errs++;
        $display("FAIL boundary_model k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, exp_font);
      end
      if (k == F + 2*D + 2 || k == 2*F + 2*D + 2) begin
        logic [7:0] w;
        w = (k < 2*F) ? 8'h24 : 8'h30;
        vecs++;
        if (fnd_font !== w) begin
          errs++;
          $display("FAIL boundary_font k=%0d: %h want %h",
                   k, fnd_font, w);
        end
      end
      if (k == F + D + 2) sec = 13;
    end
  endtask

  task automatic test_reset_midscan();
    mode_sel = 1; hour = 9; min = 45; msec = 20;
    do_reset();
    for (int k = 1; k <= F + 2*D + 2; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (fnd_comm !== 4'hF || fnd_font !== 8'hFF) begin
      errs++;
      $display("FAIL midscan_reset: %b/%h want 1111/ff",
               fnd_comm, fnd_font);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= F; k++) begin
      logic [7:0] w;
      @(negedge clk);
      w = ((k-1)/D == 2) ? 8'h40 : 8'hC0;
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== w) begin
        errs++;
        $display("FAIL midscan_restart k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, w);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      vecs++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        errs++;
        $display("FAIL random k=%0d: %b/%h want %b/%h",
                 k, fnd_comm, fnd_font, exp_comm, exp_font);
      end
      if ($urandom_range(0, 5) == 0) begin
        mode_sel = 1'($urandom);
        msec = 7'($urandom_range(0, 127));
        sec  = 6'($urandom_range(0, 63));
        min  = 6'($urandom_range(0, 63));
        hour = 5'($urandom);
      end
      rst = ($urandom_range(0, 199) != 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_blink();
    test_range();
    test_frame_boundary();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Display back-end for the stopwatch/clock: consumes the `msec`/`sec`/`min`/`hour` fields from the clock datapath and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Snapshots the time fields once per scan frame so digits never tear mid-frame.
- Converts each field to two decimal digits and encodes them to active-low segment fonts.
- Scans the digits at a parameterised rate.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clk cycles each digit is held (1 kHz digit rate at 100 MHz). Minimum legal value is 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- `mode_sel`  in  1  display mode. 0 = `sec.msec`; 1 = `hour.min`.
- `msec`  in  7  centiseconds, 0–99 nominal.
- `sec`  in  6  seconds, 0–59 nominal.
- `min`  in  6  minutes, 0–59 nominal.
- `hour`  in  5  hours.
- `fnd_comm`  out  4  digit enables, active-low, one-hot-zero. Bit 0 is the rightmost digit.
- `fnd_font`  out  8  segments, active-low. Bit order {dp,g,f,e,d,c,b,a}.

## Operation
- **Scan counter** `scan_cnt`: counts 0..SCAN_DIV-1 and wraps. When `scan_cnt`==SCAN_DIV-1, the 2-bit `digit_idx` increments, wrapping 3→0.
- **Frame end**: the cycle where `digit_idx`==3 and `scan_cnt`==SCAN_DIV-1. On that cycle, `mode_sel`, `msec`, `sec`, `min` and `hour` are latched into snapshot registers.
  - All display content comes from the snapshot only.
  - Input changes mid-frame are invisible until the next frame.
- **Field selection** (from the snapshot):
  - Low field: `msec` if mode 0, `min` if mode 1.
  - High field: `sec` if mode 0, `hour` if mode 1.
  - Both fields are zero-extended to 7 bits.
- **Digit mapping**:
  - `digit_idx` 0 = low field ones.
  - `digit_idx` 1 = low field tens.
  - `digit_idx` 2 = high field ones, carries the dp.
  - `digit_idx` 3 = high field tens.
  - Tens = v/10, ones = v%10.
- **Range rule**: if a field is ≥100 (possible for `msec` 100–127), both of its digits show '-', font 8'hBF, with no dp. The other field is unaffected.
- **Fonts** (bits 6:0, active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Bit 7 (dp) = 1 (off) except as described below.
- **Decimal point** (digit 2 only):
  - Mode 0: dp always lit (bit 7 = 0).
  - Mode 1: dp lit when snapshot `msec` < 50, off otherwise, giving a 1 Hz colon-style blink.
  - The dp is also suppressed when the high field is out of range.
- **Digit enable**: `fnd_comm` = ~(4'b0001 << `digit_idx`).
- No leading-zero blanking. Hour 5 shows "05".

## Timing
- **Reset** (`rst`==0 at a rising edge):
  - `scan_cnt`=0, `digit_idx`=0, all snapshot registers = 0.
  - `fnd_comm`=4'b1111 (all off), `fnd_font`=8'hFF.
  - A reset mid-frame aborts the frame immediately. There is no partial-frame completion.
- **Outputs** are registered, computed from the current `digit_idx` and snapshot.
  - The first clock with `rst`==1 drives `fnd_comm`=4'b1110.
  - Each digit is then held exactly SCAN_DIV cycles, with `fnd_comm` and `fnd_font` changing on the same edge.
- **First frame** after reset shows the reset snapshot (mode 0, all zero): "00.00".
  - The first live snapshot is latched at the end of frame 1, i.e. 4·SCAN_DIV cycles after reset release.
  - That snapshot becomes visible from the first cycle of frame 2.
- **Input-to-display latency**: at most 8·SCAN_DIV+1 cycles.
- **Simultaneous events**: an input change on the frame-end cycle itself is captured, because it is sampled on that edge.
- **Mode change** takes effect only at a frame boundary, for all four digits together.
- **Frame period** is exactly 4·SCAN_DIV cycles. No jitter.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles → `fnd_comm`=1111, `fnd_font`=FF. Release → next cycle `fnd_comm`=1110, `fnd_font`=C0.
- **Mode 0 display**, SCAN_DIV=4: `sec`=12, `msec`=34 held, mode 0. In frame 2, digits 0..3 show:
  - digit 0: `fnd_font`=99
  - digit 1: `fnd_font`=B0
  - digit 2: `fnd_font`=24 (2 with dp)
  - digit 3: `fnd_font`=F9
  - Each is held 4 cycles with `fnd_comm` 1110/1101/1011/0111.
- **Mode 1 blink**: `hour`=5, `min`=7. With `msec`=10 → digit 2 font 12 (dp on), digit 3 C0. Next frame with `msec`=60 → digit 2 font 92 (dp off).
- **Range**: mode 0, `msec`=115, `sec`=59 → digits 0 and 1 show BF, digit 2 shows 10, digit 3 shows 92.
- **Frame boundary**: change `sec` from 12 to 13 while `digit_idx`=1 in frame 2 → frame 2 keeps showing 12. Frame 3 digit 2 shows 30 (3 with dp).
- **Reset mid-scan**: assert `rst`=0 during `digit_idx`=2 → outputs go to 1111/FF on that edge. After release the scan restarts at digit 0 showing "00.00".
